// File: rtl/adder19_pkg.sv
// Shared constants and types for the 19-bit round-robin adder arbiter.
// Holds operand width, default requester count, saturation limits and slot state.
package adder19_pkg;

    localparam int DATA_W       = 19;
    localparam int NREQ_DEFAULT = 4;
    localparam int ID_W         = $clog2(NREQ_DEFAULT);

    localparam logic [DATA_W-1:0] SAT_MAX = 19'h3FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 19'h40000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/adder_19bit.sv
// Shared combinational 19-bit adder; zero latency, no flow control.
module adder_19bit (
    input  logic [18:0] a,
    input  logic [18:0] b,
    output logic [18:0] sum,
    output logic        carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder19_rr_arbiter.sv
// Round-robin arbiter sharing one adder; 1-cycle result latency, grants only when the result slot is free.
// Define ADDER19_SAT_EN to clamp overflowing sums to the signed limits.
module adder19_rr_arbiter
    import adder19_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = DATA_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NREQ-1:0]                       req_valid,
    input  logic [NREQ*W-1:0]                     req_a,
    input  logic [NREQ*W-1:0]                     req_b,
    output logic [NREQ-1:0]                       req_ready,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [W-1:0]                          res_sum,
    output logic                                  res_carry,
    output logic                                  res_ovf,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] res_id
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    slot_state_t     state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gidx;
    logic [NREQ-1:0] grant;
    logic            slot_free;
    logic            xfer;
    logic [W-1:0]    a_mux;
    logic [W-1:0]    b_mux;
    logic [W-1:0]    raw_sum;
    logic [W-1:0]    sum_nxt;
    logic            carry_nxt;
    logic            ovf_nxt;

    // Scan from farthest to nearest so the requester closest after ptr wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(ptr) + k) % NREQ]) begin
                grant                            = '0;
                grant[(int'(ptr) + k) % NREQ]    = 1'b1;
                gidx                             = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign slot_free = (state == EMPTY) || res_ready;
    assign req_ready = (slot_free && !rst) ? grant : '0;
    assign xfer      = |req_ready;

    assign a_mux = req_a[int'(gidx)*W +: W];
    assign b_mux = req_b[int'(gidx)*W +: W];

    adder_19bit u_add (
        .a         (a_mux),
        .b         (b_mux),
        .sum       (raw_sum),
        .carry_out (carry_nxt)
    );

    assign ovf_nxt = (a_mux[W-1] == b_mux[W-1]) && (raw_sum[W-1] != a_mux[W-1]);

`ifdef ADDER19_SAT_EN
    assign sum_nxt = ovf_nxt ? (a_mux[W-1] ? W'(SAT_MIN) : W'(SAT_MAX)) : raw_sum;
`else
    assign sum_nxt = raw_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            ptr       <= IDW'(NREQ - 1);
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
            res_id    <= '0;
        end else begin
            if (xfer) begin
                state     <= FULL;
                ptr       <= gidx;
                res_sum   <= sum_nxt;
                res_carry <= carry_nxt;
                res_ovf   <= ovf_nxt;
                res_id    <= gidx;
            end else if (state == FULL && res_ready) begin
                state <= EMPTY;
            end
        end
    end

    assign res_valid = (state == FULL);

endmodule

// File: tb/tb_adder19_rr_arbiter.sv
// Directed bench for adder19_rr_arbiter: vector table for the adder, hand sequences for arbitration and reset.
module tb_adder19_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_carry;
    logic              res_ovf;
    logic [1:0]        res_id;

    adder19_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_ovf   (res_ovf),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         id;
        logic [18:0] a;
        logic [18:0] b;
        logic [18:0] sum_wrap;
        logic [18:0] sum_sat;
        logic        carry;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [18:0] a, input logic [18:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic logic [18:0] exp_sum(input vec_t v);
`ifdef ADDER19_SAT_EN
        return v.sum_sat;
`else
        return v.sum_wrap;
`endif
    endfunction

    initial begin
        vecs[0] = '{0, 19'h00001, 19'h00001, 19'h00002, 19'h00002, 1'b0, 1'b0};
        vecs[1] = '{1, 19'h7FFFF, 19'h00001, 19'h00000, 19'h00000, 1'b1, 1'b0};
        vecs[2] = '{2, 19'h3FFFF, 19'h00001, 19'h40000, 19'h3FFFF, 1'b0, 1'b1};
        vecs[3] = '{3, 19'h40000, 19'h40000, 19'h00000, 19'h40000, 1'b1, 1'b1};
        vecs[4] = '{1, 19'h12345, 19'h00001, 19'h12346, 19'h12346, 1'b0, 1'b0};
        vecs[5] = '{2, 19'h7FFFF, 19'h7FFFF, 19'h7FFFE, 19'h7FFFE, 1'b1, 1'b0};
        vecs[6] = '{3, 19'h3FFFF, 19'h3FFFF, 19'h7FFFE, 19'h3FFFF, 1'b0, 1'b1};
        vecs[7] = '{0, 19'h40000, 19'h3FFFF, 19'h7FFFF, 19'h7FFFF, 1'b0, 1'b0};

        // Reset: outputs cleared and no grants even with every requester valid.
        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_req_ready", req_ready, 0);
        rst       = 1'b0;
        req_valid = '0;

        // Single-requester adds through the vector table.
        foreach (vecs[i]) begin
            req_valid = '0;
            set_op(vecs[i].id, vecs[i].a, vecs[i].b);
            req_valid[vecs[i].id] = 1'b1;
            res_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d_ready", i), req_ready, 32'(1) << vecs[i].id);
            step();
            chk($sformatf("tbl%0d_valid", i), res_valid, 1);
            chk($sformatf("tbl%0d_sum", i), res_sum, exp_sum(vecs[i]));
            chk($sformatf("tbl%0d_carry", i), res_carry, vecs[i].carry);
            chk($sformatf("tbl%0d_ovf", i), res_ovf, vecs[i].ovf);
            chk($sformatf("tbl%0d_id", i), res_id, vecs[i].id);
        end

        // Backpressure: slot full with res_ready low holds outputs and blocks grants.
        req_valid = 4'b0001;
        set_op(0, 19'd10, 19'd20);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        req_valid = 4'b0110;
        set_op(1, 19'd100, 19'd5);
        set_op(2, 19'd200, 19'd6);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready_zero", req_ready, 0);
            step();
            chk("bp_valid_hold", res_valid, 1);
            chk("bp_sum_hold", res_sum, 30);
            chk("bp_id_hold", res_id, 0);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_grant1", req_ready, 4'b0010);
        step();
        chk("bp_release_sum", res_sum, 105);
        chk("bp_release_id", res_id, 1);
        #1;
        chk("bp_next_grant2", req_ready, 4'b0100);
        step();
        chk("bp_next_sum", res_sum, 206);
        chk("bp_next_id", res_id, 2);

        // Asynchronous reset mid-cycle while holding a result.
        req_valid = '0;
        res_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk("arst_valid_drop", res_valid, 0);
        chk("arst_sum_clear", res_sum, 0);
        step();
        rst       = 1'b0;
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 19'(i * 100 + 1), 19'(i + 7));
        #1;
        chk("arst_first_grant0", req_ready, 4'b0001);

        // Continuous requests: grants rotate 0,1,2,3,0 at one result per cycle.
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr%0d_ready", k), req_ready, 32'(1) << (k % NREQ));
            step();
            chk($sformatf("rr%0d_valid", k), res_valid, 1);
            chk($sformatf("rr%0d_id", k), res_id, k % NREQ);
            chk($sformatf("rr%0d_sum", k), res_sum, (k % NREQ) * 100 + 1 + (k % NREQ) + 7);
        end

        // A request withdrawn before being granted must not move the pointer.
        res_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        chk("wd_ready_zero", req_ready, 0);
        step();
        chk("wd_id_hold", res_id, 0);
        req_valid = '0;
        step();
        res_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("wd_ptr_kept", req_ready, 4'b0010);
        step();
        chk("wd_id", res_id, 1);
        req_valid = '0;
        step();
        chk("drain_empty", res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder19_rr_arbiter.md
ADDER19_RR_ARBITER -- requirements
Module: adder19_rr_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter: W, 19, operand/result width in bits, two's complement.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  input  NREQ  per-requester operand-pair valid.
REQ-006 Port: req_a  input  NREQ*W  packed operand A, requester i at bits [i*W +: W].
REQ-007 Port: req_b  input  NREQ*W  packed operand B, same packing.
REQ-008 Port: req_ready  output  NREQ  one-hot grant/accept, at most one bit high.
REQ-009 Port: res_valid  output  1  result slot holds a valid result.
REQ-010 Port: res_ready  input  1  downstream accepts the result.
REQ-011 Port: res_sum  output  W  registered sum.
REQ-012 Port: res_carry  output  1  unsigned carry-out of the add.
REQ-013 Port: res_ovf  output  1  signed overflow flag.
REQ-014 Port: res_id  output  clog2(NREQ)  index of requester that produced the result.

Function
REQ-015 A transfer from requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-016 Result slot FSM SHALL have two states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-017 Slot SHALL be "free" when EMPTY, or FULL with res_ready high in the same cycle.
REQ-018 req_ready SHALL be combinational: zero when slot not free; else one-hot on the first requester with req_valid high, searching from (ptr+1) mod NREQ upward with wrap-around.
REQ-019 Round-robin pointer ptr SHALL update to the granted index only on a transfer; no transfer leaves ptr unchanged.
REQ-020 On transfer, res_sum/res_carry/res_ovf/res_id SHALL be registered next edge; latency exactly 1 cycle, res_valid high the following cycle.
REQ-021 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on res_ready with no transfer; FULL->FULL on simultaneous drain and transfer (new result replaces old, throughput 1/cycle).
REQ-022 While FULL and res_ready low, all res_* outputs SHALL hold stable.
REQ-023 res_carry SHALL be bit W of the unsigned (W+1)-bit sum of A and B.
REQ-024 res_ovf SHALL be high when A[W-1]==B[W-1] and raw sum[W-1]!=A[W-1].
REQ-025 Requester deasserting req_valid without a transfer SHALL lose nothing and SHALL not move ptr.

Reset
REQ-026 On rst assertion, asynchronously: res_valid=0, res_sum=0, res_carry=0, res_ovf=0, res_id=0, ptr=NREQ-1 (requester 0 wins first arbitration).
REQ-027 req_ready SHALL be all-zero while rst is high; reset mid-transfer SHALL discard the in-flight result.

Configuration
REQ-028 With ADDER19_SAT_EN defined, an overflowing result SHALL clamp: positive overflow -> 19'h3FFFF, negative -> 19'h40000; res_ovf still reported.
REQ-029 Without ADDER19_SAT_EN, res_sum SHALL be the wrapped W-bit sum.

Structure
REQ-030 Package adder19_pkg SHALL hold W=19, default NREQ, ID width, SAT_MAX=19'h3FFFF, SAT_MIN=19'h40000, and slot state enum {EMPTY, FULL}.
REQ-031 Datapath SHALL instantiate the existing combinational adder_19bit (a, b, sum, carry_out) once as the shared resource, fed through a NREQ:1 operand mux.

Verification
REQ-032 Reset release, req_valid=4'b0001, a0=1, b0=1, res_ready=1 -> next cycle res_valid=1, res_sum=2, res_id=0, res_carry=0, res_ovf=0.
REQ-033 All four valid continuously, res_ready=1 -> grants 0,1,2,3,0 in consecutive cycles, one result per cycle, res_id matches order.
REQ-034 a=19'h7FFFF(-1), b=1 -> res_sum=0, res_carry=1, res_ovf=0.
REQ-035 a=19'h3FFFF, b=1 -> res_ovf=1; res_sum=19'h40000 without ADDER19_SAT_EN, 19'h3FFFF with it.
REQ-036 res_ready held low 3 cycles while FULL with req_valid=4'b0110 -> req_ready=0, outputs stable; on res_ready=1, requester 1 granted same cycle and new result appears next cycle.
REQ-037 rst pulsed while res_valid=1 -> res_valid drops immediately without clock edge; first grant after release goes to requester 0.
